// File: rtl/slot_round_judge.sv
// Slot-machine round judge: waits for all reels held and stable, scores the snapshot and keeps a saturating credit count.
// Optional macro SLOT_ROUND_JUDGE_BLINK_EN makes the win output blink during SHOW instead of staying steady.
module slot_round_judge #(
  parameter int SETTLE_CYC   = 250_000,
  parameter int SHOW_CYC     = 2_000_000,
  parameter int INIT_CREDITS = 10,
  parameter int JACKPOT_PAY  = 5,
  parameter int PAIR_PAY     = 1,
  parameter int LOSS_COST    = 1,
  parameter int CREDIT_W     = 8,
  parameter int BLINK_CYC    = 250_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          h,
  input  logic [3:0]          m,
  input  logic [3:0]          l,
  input  logic [2:0]          Ctrl,
  output logic [1:0]          result,
  output logic                result_valid,
  output logic                win,
  output logic [CREDIT_W-1:0] credits,
  output logic                game_over,
  output logic                busy
);

  // One counter serves SETTLE and SHOW (disjoint states); its width also covers the blink period.
  localparam int CNT_MAX = (SHOW_CYC > SETTLE_CYC)
                         ? ((SHOW_CYC > BLINK_CYC) ? SHOW_CYC : BLINK_CYC)
                         : ((SETTLE_CYC > BLINK_CYC) ? SETTLE_CYC : BLINK_CYC);
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]    SHOW_LAST   = CNT_W'(SHOW_CYC - 1);
  localparam logic [CREDIT_W:0]   CREDIT_MAX  = {1'b0, {CREDIT_W{1'b1}}};
  localparam logic [CREDIT_W:0]   P_JACK      = (CREDIT_W+1)'(JACKPOT_PAY);
  localparam logic [CREDIT_W:0]   P_PAIR      = (CREDIT_W+1)'(PAIR_PAY);
  localparam logic [CREDIT_W:0]   P_LOSS      = (CREDIT_W+1)'(LOSS_COST);
  localparam logic [CREDIT_W-1:0] CREDIT_INIT = CREDIT_W'(INIT_CREDITS);

  typedef enum logic [2:0] {
    ST_SPIN,
    ST_SETTLE,
    ST_JUDGE,
    ST_SHOW,
    ST_RELEASE
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [11:0]         r_snapshot;
  logic [CNT_W-1:0]    r_cnt;
  logic [11:0]         w_reels;
  logic                w_allHeld;
  logic                w_stable;
  logic [1:0]          w_judge;
  logic [CREDIT_W:0]   w_wide;
  logic [CREDIT_W:0]   w_sum;
  logic [CREDIT_W-1:0] w_newCredits;

  assign w_reels   = {h, m, l};
  assign w_allHeld = (Ctrl == 3'b111);
  assign w_stable  = (w_reels == r_snapshot);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_SPIN;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_SPIN:    if (w_allHeld && !game_over) w_nextState = ST_SETTLE;
      ST_SETTLE: begin
        if (!w_allHeld)                              w_nextState = ST_SPIN;
        else if (w_stable && (r_cnt == SETTLE_LAST)) w_nextState = ST_JUDGE;
      end
      ST_JUDGE:   w_nextState = ST_SHOW;
      ST_SHOW:    if (r_cnt == SHOW_LAST) w_nextState = ST_RELEASE;
      ST_RELEASE: if (Ctrl == 3'b000) w_nextState = ST_SPIN;
      default:    w_nextState = ST_SPIN;
    endcase
  end

  always_comb begin
    w_judge = 2'b01;
    if ((r_snapshot[11:8] == r_snapshot[7:4]) && (r_snapshot[7:4] == r_snapshot[3:0]))
      w_judge = 2'b11;
    else if ((r_snapshot[11:8] == r_snapshot[7:4]) || (r_snapshot[7:4] == r_snapshot[3:0]) ||
             (r_snapshot[11:8] == r_snapshot[3:0]))
      w_judge = 2'b10;
  end

  // Credit math runs one bit wider so the top saturation can be detected before truncation.
  always_comb begin
    w_wide = {1'b0, credits};
    w_sum  = w_wide;
    case (w_judge)
      2'b11:   w_sum = w_wide + P_JACK;
      2'b10:   w_sum = w_wide + P_PAIR;
      default: w_sum = (w_wide < P_LOSS) ? '0 : (w_wide - P_LOSS);
    endcase
    w_newCredits = (w_sum > CREDIT_MAX) ? CREDIT_MAX[CREDIT_W-1:0] : w_sum[CREDIT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snapshot   <= '0;
      r_cnt        <= '0;
      result       <= 2'b00;
      result_valid <= 1'b0;
      credits      <= CREDIT_INIT;
      game_over    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      busy         <= (w_nextState == ST_SETTLE) || (w_nextState == ST_JUDGE) || (w_nextState == ST_SHOW);
      case (r_state)
        ST_SPIN: begin
          if (w_nextState == ST_SETTLE) begin
            r_snapshot <= w_reels;
            r_cnt      <= '0;
          end
        end
        ST_SETTLE: begin
          if (w_allHeld) begin
            if (!w_stable) begin
              r_snapshot <= w_reels;
              r_cnt      <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_JUDGE: begin
          result       <= w_judge;
          credits      <= w_newCredits;
          result_valid <= 1'b1;
          r_cnt        <= '0;
          if (w_newCredits == '0) game_over <= 1'b1;
        end
        ST_SHOW:  r_cnt <= r_cnt + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef SLOT_ROUND_JUDGE_BLINK_EN
  logic [CNT_W-1:0] r_blinkCnt;
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYC - 1);

  // Win starts high on SHOW entry and toggles every BLINK_CYC cycles, only for pair/jackpot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win        <= 1'b0;
      r_blinkCnt <= '0;
    end else if (w_nextState != ST_SHOW) begin
      win        <= 1'b0;
      r_blinkCnt <= '0;
    end else if (r_state == ST_JUDGE) begin
      win        <= w_judge[1];
      r_blinkCnt <= '0;
    end else if (r_blinkCnt == BLINK_LAST) begin
      win        <= result[1] & ~win;
      r_blinkCnt <= '0;
    end else begin
      r_blinkCnt <= r_blinkCnt + 1'b1;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          win <= 1'b0;
    else if (w_nextState != ST_SHOW)  win <= 1'b0;
    else if (r_state == ST_JUDGE)     win <= w_judge[1];
  end
`endif

endmodule

// File: tb/tb_slot_round_judge.sv
// Directed self-checking bench for slot_round_judge with short settle/show/blink periods.
// Expected results and credits come from hand-computed vectors and a small saturating credit model.
module tb_slot_round_judge;

  localparam int SETTLE_CYC = 8;
  localparam int SHOW_CYC   = 16;
  localparam int BLINK_CYC  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] h, m, l;
  logic [2:0] Ctrl;
  logic [1:0] result;
  logic       result_valid, win, game_over, busy;
  logic [7:0] credits;

  int checks = 0;
  int errors = 0;
  int expCredits = 10;

  always #5 clk = ~clk;

  slot_round_judge #(
    .SETTLE_CYC(SETTLE_CYC), .SHOW_CYC(SHOW_CYC), .INIT_CREDITS(10), .JACKPOT_PAY(5),
    .PAIR_PAY(1), .LOSS_COST(1), .CREDIT_W(8), .BLINK_CYC(BLINK_CYC)
  ) dut (
    .clk(clk), .rst(rst), .h(h), .m(m), .l(l), .Ctrl(Ctrl),
    .result(result), .result_valid(result_valid), .win(win),
    .credits(credits), .game_over(game_over), .busy(busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [1:0] expResult(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    if (a == b && b == c) return 2'b11;
    if (a == b || b == c || a == c) return 2'b10;
    return 2'b01;
  endfunction

  function automatic int nextCredits(input int cur, input logic [1:0] r);
    int n;
    case (r)
      2'b11:   n = cur + 5;
      2'b10:   n = cur + 1;
      default: n = cur - 1;
    endcase
    if (n > 255) n = 255;
    if (n < 0) n = 0;
    return n;
  endfunction

  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [2:0] ctl);
    h = a; m = b; l = c; Ctrl = ctl;
  endtask

  task automatic applyReset;
    rst = 1'b1;
    applyStimulus(4'd0, 4'd0, 4'd0, 3'b000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    expCredits = 10;
  endtask

  // Counts negedges until result_valid; returns -1 if it never comes.
  task automatic waitValid(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (result_valid) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic playRound(input string tag, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    int         cyc;
    logic [1:0] er;
    applyStimulus(a, b, c, 3'b111);
    @(negedge clk);
    waitValid(cyc);
    er = expResult(a, b, c);
    expCredits = nextCredits(expCredits, er);
    checkOutput({tag, ".latency"}, cyc, SETTLE_CYC + 1);
    checkOutput({tag, ".result"}, result, er);
    checkOutput({tag, ".credits"}, credits, expCredits);
    checkOutput({tag, ".win"}, win, er[1]);
    checkOutput({tag, ".gameover"}, game_over, (expCredits == 0));
    Ctrl = 3'b000;
    repeat (SHOW_CYC + 3) @(negedge clk);
  endtask

  initial begin
    int          cyc;
    int          winHigh;
    int          expWinHigh;
    logic        sawValid;
    logic        sawBusy;
    logic [15:0] winPat;
    logic [15:0] expPat;

    rst = 1'b1;
    applyStimulus(4'd0, 4'd0, 4'd0, 3'b000);
    @(negedge clk);
    checkOutput("rst.credits_during", credits, 10);
    checkOutput("rst.busy_during", busy, 0);
    applyReset;
    checkOutput("rst.result", result, 0);
    checkOutput("rst.valid", result_valid, 0);
    checkOutput("rst.win", win, 0);
    checkOutput("rst.credits", credits, 10);
    checkOutput("rst.gameover", game_over, 0);
    checkOutput("rst.busy", busy, 0);

    // 1: jackpot from reset, win duration
    applyStimulus(4'd2, 4'd2, 4'd2, 3'b111);
    @(negedge clk);
    checkOutput("t1.busy", busy, 1);
    checkOutput("t1.noValidYet", result_valid, 0);
    waitValid(cyc);
    checkOutput("t1.latency", cyc, SETTLE_CYC + 1);
    checkOutput("t1.result", result, 3);
    checkOutput("t1.credits", credits, 15);
    Ctrl = 3'b000;
    winHigh = 0;
    sawValid = 1'b0;
    for (int i = 0; i < SHOW_CYC + 4; i++) begin
      if (win) winHigh++;
      if (i > 0 && result_valid) sawValid = 1'b1;
      @(negedge clk);
    end
`ifdef SLOT_ROUND_JUDGE_BLINK_EN
    expWinHigh = SHOW_CYC / 2;
`else
    expWinHigh = SHOW_CYC;
`endif
    checkOutput("t1.winCycles", winHigh, expWinHigh);
    checkOutput("t1.validPulse", sawValid, 0);
    checkOutput("t1.busyAfter", busy, 0);
    checkOutput("t1.resultHeld", result, 3);

    // 2: pair then loss from reset
    applyReset;
    playRound("t2pair", 4'd1, 4'd1, 4'd3);
    checkOutput("t2.pairCredits", credits, 11);
    playRound("t2loss", 4'd0, 4'd1, 4'd2);
    checkOutput("t2.lossCredits", credits, 10);

    // 3: reel change mid-settle restarts the count
    applyStimulus(4'd3, 4'd1, 4'd2, 3'b111);
    repeat (5) @(negedge clk);
    l = 4'd0;
    @(negedge clk);
    waitValid(cyc);
    expCredits = nextCredits(expCredits, 2'b01);
    checkOutput("t3.restartLatency", cyc, SETTLE_CYC + 1);
    checkOutput("t3.result", result, 1);
    checkOutput("t3.credits", credits, expCredits);
    Ctrl = 3'b000;
    repeat (SHOW_CYC + 3) @(negedge clk);

    // 3b: hold released mid-settle aborts the round
    applyStimulus(4'd2, 4'd2, 4'd2, 3'b111);
    repeat (4) @(negedge clk);
    checkOutput("t3.abortBusyBefore", busy, 1);
    Ctrl = 3'b011;
    sawValid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (result_valid) sawValid = 1'b1;
    end
    checkOutput("t3.abortNoValid", sawValid, 0);
    checkOutput("t3.abortBusy", busy, 0);
    checkOutput("t3.abortCredits", credits, expCredits);
    checkOutput("t3.abortResult", result, 1);
    Ctrl = 3'b000;
    @(negedge clk);

    // 4: ten losses to game over, then frozen
    applyReset;
    for (int i = 0; i < 10; i++) playRound("t4loss", 4'd0, 4'd1, 4'd2);
    checkOutput("t4.credits", credits, 0);
    checkOutput("t4.gameover", game_over, 1);
    applyStimulus(4'd1, 4'd1, 4'd1, 3'b111);
    sawBusy = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) sawBusy = 1'b1;
    end
    checkOutput("t4.noBusy", sawBusy, 0);
    checkOutput("t4.frozen", credits, 0);
    applyReset;
    checkOutput("t4.rstCredits", credits, 10);
    checkOutput("t4.rstGameover", game_over, 0);

    // 5: climb to 254, jackpot saturates at 255
    for (int i = 0; i < 48; i++) playRound("t5jack", 4'd1, 4'd1, 4'd1);
    for (int i = 0; i < 4; i++) playRound("t5pair", 4'd2, 4'd2, 4'd0);
    checkOutput("t5.at254", credits, 254);
    playRound("t5sat", 4'd3, 4'd3, 4'd3);
    checkOutput("t5.saturated", credits, 255);
    playRound("t5sat2", 4'd0, 4'd0, 4'd0);
    checkOutput("t5.stillSat", credits, 255);

    // 5b: async reset in the middle of SHOW
    applyStimulus(4'd3, 4'd3, 4'd3, 3'b111);
    @(negedge clk);
    waitValid(cyc);
    repeat (2) @(negedge clk);
    checkOutput("t5.showWin", win, 1);
    checkOutput("t5.showBusy", busy, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t5.rstWin", win, 0);
    checkOutput("t5.rstBusy", busy, 0);
    checkOutput("t5.rstCredits", credits, 10);
    checkOutput("t5.rstResult", result, 0);
    @(negedge clk);
    applyStimulus(4'd0, 4'd0, 4'd0, 3'b000);
    rst = 1'b0;
    @(negedge clk);
    expCredits = 10;

    // 6: win pattern through SHOW on a pair
    applyStimulus(4'd1, 4'd2, 4'd1, 3'b111);
    @(negedge clk);
    waitValid(cyc);
    checkOutput("t6.result", result, 2);
    Ctrl = 3'b000;
    for (int i = 0; i < SHOW_CYC; i++) begin
      winPat[i] = win;
`ifdef SLOT_ROUND_JUDGE_BLINK_EN
      expPat[i] = (((i / BLINK_CYC) % 2) == 0);
`else
      expPat[i] = 1'b1;
`endif
      @(negedge clk);
    end
    checkOutput("t6.winPattern", winPat, expPat);
    checkOutput("t6.winAfter", win, 0);
    checkOutput("t6.credits", credits, 11);
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
